// File: rtl/ps2_count_bcd_scheduler_pkg.sv
// Shared definitions for the z-axis BCD scheduler and the text generator that consumes its digits.
// Holds the FSM state encodings and the default count and digit widths.
// No logic lives here.
package ps2_count_bcd_scheduler_pkg;

  localparam int COUNT_W_DEFAULT = 16;
  localparam int DIGITS_DEFAULT  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/ps2_count_bcd_scheduler_bcd_digit_adjust.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more.
// Purely combinational, zero latency.
// No handshake.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Pre-shift correction so that the following doubling carries into the next decade.
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) adjusted = digit + 4'd3;
  end

endmodule

// File: rtl/ps2_count_bcd_scheduler.sv
// Converts the binary tracking count to BCD digits and commits them to the overlay only at frame_tick.
// Latency: count_valid in IDLE at cycle 0 reaches HOLD at cycle COUNT_W+1; outputs follow on the next HOLD frame_tick.
// Counts arriving while busy are parked in a one-entry slot (latest wins); nothing is ever stalled.
module ps2_count_bcd_scheduler
  import ps2_count_bcd_scheduler_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT,
  parameter int DIGITS  = DIGITS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COUNT_W-1:0] count_in,
  input  logic               count_valid,
  input  logic               frame_tick,
  output logic [3:0]         z_axis_ten_thousands,
  output logic [3:0]         z_axis_thousands,
  output logic [3:0]         z_axis_hundreds,
  output logic [3:0]         z_axis_tens,
  output logic [3:0]         z_axis_units,
  output logic               busy,
  output logic               pending
);

  localparam int ACC_W  = DIGITS * 4;
  localparam int CAT_W  = ACC_W + COUNT_W;
  localparam int ITER_W = $clog2(COUNT_W + 1);

  state_t             state;
  state_t             state_next;
  logic [ITER_W-1:0]  iter;
  logic [COUNT_W-1:0] shift_reg;
  logic [COUNT_W-1:0] slot;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_next;
  logic [COUNT_W-1:0] shift_next;
  logic [CAT_W-1:0]   shifted;
  logic [ACC_W-1:0]   result;
  logic [ACC_W-1:0]   disp;
  logic               last_iter;
  logic               commit;

  // One correction cell per BCD decade of the accumulator.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (acc[g*4 +: 4]),
      .adjusted (acc_adj[g*4 +: 4])
    );
  end

  assign shifted    = {acc_adj, shift_reg} << 1;
  assign acc_next   = shifted[CAT_W-1:COUNT_W];
  assign shift_next = shifted[COUNT_W-1:0];
  assign last_iter  = (iter == ITER_W'(COUNT_W - 1));
  assign commit     = (state == ST_HOLD) && frame_tick;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state: frame_tick only matters in HOLD, so the display never changes mid-frame.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (count_valid) state_next = ST_CONVERT;
      ST_CONVERT: if (last_iter)   state_next = ST_HOLD;
      ST_HOLD: begin
        if (frame_tick) state_next = (count_valid || pending) ? ST_CONVERT : ST_IDLE;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  // FSM outputs decoded straight from the state.
  always_comb begin
    busy = (state == ST_CONVERT) || (state == ST_HOLD);
  end

  // Conversion datapath, pending slot and display commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      iter      <= '0;
      shift_reg <= '0;
      acc       <= '0;
      result    <= '0;
      disp      <= '0;
      slot      <= '0;
      pending   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count_valid) begin
            shift_reg <= count_in;
            acc       <= '0;
            iter      <= '0;
          end
        end
        ST_CONVERT: begin
          acc       <= acc_next;
          shift_reg <= shift_next;
          iter      <= iter + ITER_W'(1);
          if (last_iter) begin
            result <= acc_next;
            iter   <= '0;
          end
          if (count_valid) begin
            slot    <= count_in;
            pending <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (commit) begin
            disp <= result;
            acc  <= '0;
            iter <= '0;
            // A count arriving with the commit is newer than the slot, so it goes straight in.
            if (count_valid) begin
              shift_reg <= count_in;
              pending   <= 1'b0;
            end else if (pending) begin
              shift_reg <= slot;
              pending   <= 1'b0;
            end
          end else if (count_valid) begin
            slot    <= count_in;
            pending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign z_axis_units         = disp[0*4 +: 4];
  assign z_axis_tens          = disp[1*4 +: 4];
  assign z_axis_hundreds      = disp[2*4 +: 4];
  assign z_axis_thousands     = disp[3*4 +: 4];
  assign z_axis_ten_thousands = disp[4*4 +: 4];

endmodule

// File: tb/tb_ps2_count_bcd_scheduler.sv
// Directed bench for the BCD scheduler: reset, conversion values, pending slot, tick gating, mid-conversion reset.
// Inputs are driven 1 ns after the rising edge; outputs are sampled at that same point.
// Cycle numbers in the tasks are relative to the cycle in which the first count_valid is driven.
module tb_ps2_count_bcd_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] count_in = '0;
  logic        count_valid = 1'b0;
  logic        frame_tick = 1'b0;
  logic [3:0]  d4, d3, d2, d1, d0;
  logic        busy, pending;
  logic [19:0] digs;

  int checks = 0;
  int errors = 0;

  assign digs = {d4, d3, d2, d1, d0};

  always #5 clk = ~clk;

  ps2_count_bcd_scheduler #(.COUNT_W(16), .DIGITS(5)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .count_in             (count_in),
    .count_valid          (count_valid),
    .frame_tick           (frame_tick),
    .z_axis_ten_thousands (d4),
    .z_axis_thousands     (d3),
    .z_axis_hundreds      (d2),
    .z_axis_tens          (d1),
    .z_axis_units         (d0),
    .busy                 (busy),
    .pending              (pending)
  );

  // Advance one cycle; single-cycle pulses drop afterwards.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      count_valid = 1'b0;
      frame_tick  = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cyc(2);
    checks++; if (digs !== 20'h00000) begin errors++; $display("FAIL reset_digits got %h want %h", digs, 20'h00000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
    reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic;
    int bad_busy = 0;
    count_in = 16'd12345; count_valid = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_c0 got %b want 0", busy); end
    cyc(1);
    for (int c = 1; c <= 30; c++) begin
      if (busy !== 1'b1) bad_busy++;
      if (c == 29) begin
        checks++; if (digs !== 20'h00000) begin errors++; $display("FAIL basic_digits_before_tick got %h want %h", digs, 20'h00000); end
      end
      if (c == 30) frame_tick = 1'b1;
      cyc(1);
    end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL basic_busy_window got %0d low cycles want 0", bad_busy); end
    checks++; if (digs !== 20'h12345) begin errors++; $display("FAIL basic_digits got %h want %h", digs, 20'h12345); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_extremes;
    count_in = 16'd65535; count_valid = 1'b1;
    cyc(17);
    frame_tick = 1'b1;
    cyc(1);
    checks++; if (digs !== 20'h65535) begin errors++; $display("FAIL max_digits got %h want %h", digs, 20'h65535); end
    count_in = 16'd0; count_valid = 1'b1;
    cyc(17);
    checks++; if (digs !== 20'h65535) begin errors++; $display("FAIL zero_hold_unchanged got %h want %h", digs, 20'h65535); end
    frame_tick = 1'b1;
    cyc(1);
    checks++; if (digs !== 20'h00000) begin errors++; $display("FAIL zero_digits got %h want %h", digs, 20'h00000); end
  endtask

  task automatic test_pending;
    count_in = 16'd100; count_valid = 1'b1;
    cyc(5);
    count_in = 16'd200; count_valid = 1'b1;
    cyc(4);
    count_in = 16'd300; count_valid = 1'b1;
    cyc(1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pend_set got %b want 1", pending); end
    cyc(7);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pend_in_hold got %b want 1", pending); end
    frame_tick = 1'b1;
    cyc(1);
    checks++; if (digs !== 20'h00100) begin errors++; $display("FAIL pend_first_commit got %h want %h", digs, 20'h00100); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL pend_cleared got %b want 0", pending); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pend_restart_busy got %b want 1", busy); end
    cyc(16);
    frame_tick = 1'b1;
    cyc(1);
    checks++; if (digs !== 20'h00300) begin errors++; $display("FAIL pend_second_commit got %h want %h", digs, 20'h00300); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pend_idle_after got %b want 0", busy); end
  endtask

  task automatic test_tick_gating;
    int changed = 0;
    count_in = 16'd777; count_valid = 1'b1;
    cyc(1);
    for (int c = 1; c <= 20; c++) begin
      if (digs !== 20'h00300) changed++;
      if (c % 4 == 0) frame_tick = 1'b1;
      cyc(1);
    end
    checks++; if (changed != 0) begin errors++; $display("FAIL gate_unchanged got %0d changed cycles want 0", changed); end
    checks++; if (digs !== 20'h00777) begin errors++; $display("FAIL gate_commit got %h want %h", digs, 20'h00777); end
  endtask

  task automatic test_reset_mid_convert;
    count_in = 16'd4321; count_valid = 1'b1;
    cyc(4);
    count_in = 16'd1234; count_valid = 1'b1;
    cyc(1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rst_pend_before got %b want 1", pending); end
    cyc(3);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    checks++; if (digs !== 20'h00000) begin errors++; $display("FAIL rst_digits got %h want %h", digs, 20'h00000); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b want 0", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    cyc(20);
    frame_tick = 1'b1;
    cyc(1);
    checks++; if (digs !== 20'h00000) begin errors++; $display("FAIL rst_tick_digits got %h want %h", digs, 20'h00000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_tick_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    count_in = 16'd50; count_valid = 1'b1;
    cyc(17);
    count_in = 16'd60; count_valid = 1'b1; frame_tick = 1'b1;
    cyc(1);
    checks++; if (digs !== 20'h00050) begin errors++; $display("FAIL b2b_first got %h want %h", digs, 20'h00050); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL b2b_pending got %b want 0", pending); end
    cyc(16);
    frame_tick = 1'b1;
    cyc(1);
    checks++; if (digs !== 20'h00060) begin errors++; $display("FAIL b2b_second got %h want %h", digs, 20'h00060); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", busy); end
  endtask

  initial begin
    #1;
    test_reset;
    test_basic;
    test_extremes;
    test_pending;
    test_tick_gating;
    test_reset_mid_convert;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_count_bcd_scheduler.md
PS2_COUNT_BCD_SCHEDULER -- requirements
Module: ps2_count_bcd_scheduler

Interface
REQ-001 Parameter COUNT_W, default 16: width of the binary tracking count.
REQ-002 Parameter DIGITS, default 5: number of BCD digits driven to the text generator.
REQ-003 clk  input  1: single system clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1: reset, synchronous, active-low.
REQ-005 count_in  input  COUNT_W: binary tracking count from the mouse datapath.
REQ-006 count_valid  input  1: one-cycle pulse; count_in is valid in that cycle.
REQ-007 frame_tick  input  1: one-cycle pulse at start of vertical blanking.
REQ-008 z_axis_ten_thousands, z_axis_thousands, z_axis_hundreds, z_axis_tens, z_axis_units  output  4 each: registered BCD digits for the text overlay.
REQ-009 busy  output  1: high while state is CONVERT or HOLD.
REQ-010 pending  output  1: high while a captured count waits for conversion.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CONVERT, HOLD.
REQ-012 IDLE + count_valid SHALL capture count_in into the shift register, clear the BCD accumulator and enter CONVERT on the next edge.
REQ-013 CONVERT SHALL run shift-add-3 (double dabble): in each cycle, every BCD nibble >= 5 is incremented by 3, then {BCD, binary} is shifted left by 1.
REQ-014 CONVERT SHALL last exactly COUNT_W cycles, counted by an iteration counter, then enter HOLD.
REQ-015 In HOLD, the converted result SHALL stay in an internal result register. The display outputs SHALL NOT change.
REQ-016 HOLD + frame_tick SHALL copy the result to the five output digits on that edge.
REQ-017 On that same HOLD + frame_tick edge, the FSM SHALL go to CONVERT if pending was set, else to IDLE.
REQ-018 Outputs SHALL change only on a HOLD + frame_tick edge, so the display never tears mid-frame.
REQ-019 frame_tick in IDLE or CONVERT SHALL be ignored.
REQ-020 count_valid in CONVERT or HOLD SHALL store count_in in a one-entry pending slot and set pending. The latest value wins, and the in-flight conversion is not disturbed.
REQ-021 Starting a conversion from the pending slot SHALL clear pending in the same edge.
REQ-022 count_valid and the commit in the same HOLD cycle SHALL start CONVERT directly with that count_in, bypassing the slot. pending ends cleared.
REQ-023 Latency: count_valid in IDLE at cycle 0 SHALL give HOLD at cycle COUNT_W+1. Outputs update on the first frame_tick edge at or after that cycle.
REQ-024 Digits above units SHALL show 0 for leading positions; no leading-blank suppression. All 16-bit inputs fit in five digits, so no overflow flag exists.
REQ-025 busy SHALL be combinational from state. pending SHALL be a register.

Reset
REQ-026 When reset_n = 0 on an edge, the following SHALL happen: state IDLE; all digits 0; busy 0; pending 0; iteration counter, shift, accumulator and slot registers 0.
REQ-027 Reset mid-CONVERT or in HOLD SHALL discard the conversion and pending value. The next frame_tick SHALL leave the digits at 0.

Structure
REQ-028 A shared header SHALL hold the state encodings (IDLE=2'd0, CONVERT=2'd1, HOLD=2'd2) and the COUNT_W and DIGITS defaults. The text generator includes the same header.
REQ-029 One combinational sub-module, bcd_digit_adjust (4-bit in, +3 if >=5, 4-bit out), SHALL be instantiated once per digit.
REQ-030 The block SHALL contain no font-ROM or pixel logic; it only feeds the digit inputs of the text generator.

Verification
REQ-031 Reset, count_in=12345 valid, frame_tick at cycle 30 -> digits 1,2,3,4,5 after that edge; busy high cycles 1-30.
REQ-032 count_in=65535 and then 0 in separate frames -> 6,5,5,3,5 then 0,0,0,0,0.
REQ-033 Valid 100 at cycle 0, then 200 at cycle 5 and 300 at cycle 9 (all during CONVERT) -> first commit shows 0,0,1,0,0; pending=1; second commit shows 0,0,3,0,0.
REQ-034 frame_tick every 4 cycles during CONVERT of 777 -> digits unchanged until the first tick after HOLD is entered.
REQ-035 reset_n low at CONVERT cycle 8 of 4321, then frame_tick -> digits stay 0, state IDLE, pending 0.
REQ-036 In HOLD for 50: count_valid=60 coincident with frame_tick -> digits 0,0,0,5,0, CONVERT entered, next commit shows 0,0,0,6,0.
